// File: rtl/ram_arbiter.sv
// Round-robin arbiter between two clients sharing one RAM256x64.
// Each access runs IDLE -> ACCESS -> WAIT -> ACK, so a registered read has a cycle to settle.
module ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy
);

  // state  | meaning
  // IDLE   | waiting for a request; grants on the clock edge
  // ACCESS | RAM pins driven; a write commits at the end of this cycle
  // WAIT   | registered RAM output becomes valid
  // ACK    | one-cycle ack to the granted port
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] ACK    = 2'd3;

  logic [1:0] state;
  logic       wr_flag;
  logic       sel_b;
  logic       prio_b;
  logic       grant_b;

  // B wins only if A is idle or the pointer favours B.
  assign grant_b = b_req && (!a_req || prio_b);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wr_flag     <= 1'b0;
      sel_b       <= 1'b0;
      prio_b      <= 1'b0;
      ram_address <= '0;
      ram_in      <= '0;
      a_rdata     <= '0;
      b_rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            sel_b       <= grant_b;
            prio_b      <= !grant_b;
            ram_address <= grant_b ? b_addr  : a_addr;
            ram_in      <= grant_b ? b_wdata : a_wdata;
            wr_flag     <= grant_b ? b_write : a_write;
            state       <= ACCESS;
          end
        end
        ACCESS: state <= WAIT;
        WAIT: begin
          if (!wr_flag) begin
            if (sel_b) b_rdata <= ram_out;
            else       a_rdata <= ram_out;
          end
          state <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ram_write = (state == ACCESS) && wr_flag;
  assign a_ack     = (state == ACK) && !sel_b;
  assign b_ack     = (state == ACK) && sel_b;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: behavioural RAM, per-port operation queues and a
// transaction-level model of grant order, memory contents and returned data.
module tb_ram_arbiter;

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [63:0] data;
  } op_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        a_req = 1'b0, a_write = 1'b0, b_req = 1'b0, b_write = 1'b0;
  logic [7:0]  a_addr = '0, b_addr = '0;
  logic [63:0] a_wdata = '0, b_wdata = '0;
  logic        a_ack, b_ack, ram_write, busy;
  logic [63:0] a_rdata, b_rdata, ram_in;
  logic [7:0]  ram_address;
  logic [63:0] ram_out;

  logic        fill_en = 1'b0;
  logic [7:0]  fill_addr = '0;
  logic [63:0] fill_data = '0;
  logic [63:0] mem [256];

  op_t         qa[$];
  op_t         qb[$];
  logic [63:0] shadow [256];
  logic        prio_m;
  logic [63:0] a_rd_m, b_rd_m;
  int          n_cmp = 0;
  int          n_bad = 0;

  ram_arbiter #(.ADDR_W(8), .DATA_W(64)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .ram_address(ram_address), .ram_in(ram_in), .ram_write(ram_write),
    .ram_out(ram_out), .busy(busy)
  );

  always #5 clock = ~clock;

  // RAM256x64: synchronous write, registered read.
  always @(posedge clock) begin
    if (fill_en) mem[fill_addr] <= fill_data;
    else if (ram_write) mem[ram_address] <= ram_in;
    ram_out <= mem[ram_address];
  end

  task automatic drive_fronts();
    a_req = (qa.size() > 0);
    b_req = (qb.size() > 0);
    if (qa.size() > 0) begin a_write = qa[0].wr; a_addr = qa[0].addr; a_wdata = qa[0].data; end
    if (qb.size() > 0) begin b_write = qb[0].wr; b_addr = qb[0].addr; b_wdata = qb[0].data; end
  endtask

  task automatic model_reset();
    prio_m = 1'b0;
    a_rd_m = '0;
    b_rd_m = '0;
  endtask

  // Serves both queues until empty, checking every cycle against the model.
  task automatic run_queues(input bit drop_at_access);
    int          p;
    op_t         o;
    logic [63:0] exp_rd;
    drive_fronts();
    while (qa.size() > 0 || qb.size() > 0) begin
      if (qa.size() > 0 && qb.size() > 0) p = int'(prio_m);
      else p = (qa.size() > 0) ? 0 : 1;
      prio_m = (p == 0);
      o = (p == 0) ? qa[0] : qb[0];
      exp_rd = shadow[o.addr];
      if (o.wr) shadow[o.addr] = o.data;
      for (int ph = 0; ph < 4; ph++) begin
        @(negedge clock);
        if (ph == 2 && !o.wr) begin
          if (p == 0) a_rd_m = exp_rd;
          else        b_rd_m = exp_rd;
        end
        n_cmp++;
        if (ram_write !== (ph == 0 && o.wr)) begin
          n_bad++;
          $display("FAIL ram_write port%0d ph%0d: got %b exp %b", p, ph, ram_write, (ph == 0 && o.wr));
        end
        if (ph < 3) begin
          n_cmp++;
          if (ram_address !== o.addr || ram_in !== o.data) begin
            n_bad++;
            $display("FAIL ram_pins port%0d ph%0d: got %h/%h exp %h/%h", p, ph, ram_address, ram_in, o.addr, o.data);
          end
        end
        n_cmp++;
        if (a_ack !== (ph == 2 && p == 0) || b_ack !== (ph == 2 && p == 1)) begin
          n_bad++;
          $display("FAIL acks port%0d ph%0d: got a=%b b=%b", p, ph, a_ack, b_ack);
        end
        n_cmp++;
        if (busy !== (ph != 3)) begin
          n_bad++;
          $display("FAIL busy ph%0d: got %b exp %b", ph, busy, (ph != 3));
        end
        n_cmp++;
        if (a_rdata !== a_rd_m || b_rdata !== b_rd_m) begin
          n_bad++;
          $display("FAIL rdata ph%0d: got a=%h b=%h exp a=%h b=%h", ph, a_rdata, b_rdata, a_rd_m, b_rd_m);
        end
        if (ph == 0 && drop_at_access) begin
          if (p == 0) a_req = 1'b0;
          else        b_req = 1'b0;
        end
        if (ph == 2) begin
          if (p == 0) void'(qa.pop_front());
          else        void'(qb.pop_front());
          drive_fronts();
        end
      end
    end
  endtask

  task automatic check_outputs_zero(input string name);
    n_cmp++;
    if (a_ack !== 1'b0 || b_ack !== 1'b0 || a_rdata !== '0 || b_rdata !== '0 ||
        ram_address !== '0 || ram_in !== '0 || ram_write !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got ack=%b%b rd=%h/%h addr=%h in=%h wr=%b busy=%b exp all zero",
               name, a_ack, b_ack, a_rdata, b_rdata, ram_address, ram_in, ram_write, busy);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [63:0] v;
    model_reset();
    for (int i = 0; i < 256; i++) begin
      @(negedge clock);
      if (i == 0) check_outputs_zero("reset_state");
      v = {$urandom, $urandom};
      fill_en = 1'b1; fill_addr = 8'(i); fill_data = v;
      shadow[i] = v;
    end
    @(negedge clock);
    fill_en = 1'b0;
    check_outputs_zero("reset_after_fill");
    reset = 1'b0;
  endtask

  task automatic test_write_a();
    qa.push_back('{1'b1, 8'h05, 64'h0123456789ABCDEF});
    run_queues(1'b0);
  endtask

  task automatic test_read_a();
    qa.push_back('{1'b0, 8'h05, 64'h0});
    run_queues(1'b0);
    repeat (3) begin
      @(negedge clock);
      n_cmp++;
      if (a_rdata !== 64'h0123456789ABCDEF) begin
        n_bad++;
        $display("FAIL read_a_hold: got %h exp %h", a_rdata, 64'h0123456789ABCDEF);
      end
    end
  endtask

  task automatic test_contention();
    apply_reset();
    qa.push_back('{1'b0, 8'h10, 64'h0});
    qb.push_back('{1'b1, 8'h10, 64'hFFFF0000FFFF0000});
    run_queues(1'b0);
    qb.push_back('{1'b0, 8'h10, 64'h0});
    run_queues(1'b0);
    n_cmp++;
    if (b_rdata !== 64'hFFFF0000FFFF0000) begin
      n_bad++;
      $display("FAIL contention_readback: got %h exp %h", b_rdata, 64'hFFFF0000FFFF0000);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      qa.push_back('{1'($urandom), 8'($urandom), {$urandom, $urandom}});
      qb.push_back('{1'($urandom), 8'($urandom), {$urandom, $urandom}});
    end
    run_queues(1'b0);
  endtask

  task automatic test_withdraw();
    logic [63:0] v;
    v = {$urandom, $urandom};
    qb.push_back('{1'b1, 8'hFF, v});
    run_queues(1'b1);
    qa.push_back('{1'b0, 8'hFF, 64'h0});
    run_queues(1'b0);
    n_cmp++;
    if (a_rdata !== v) begin
      n_bad++;
      $display("FAIL withdraw_commit: got %h exp %h", a_rdata, v);
    end
  endtask

  task automatic test_reset_mid();
    a_req = 1'b1; a_write = 1'b0; a_addr = 8'h33; a_wdata = '0;
    @(negedge clock);
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b1 || a_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_wait: got busy=%b ack=%b exp 1/0", busy, a_ack);
    end
    reset = 1'b1;
    #1;
    check_outputs_zero("reset_mid_immediate");
    a_req = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clock);
      check_outputs_zero("reset_mid_held");
    end
    reset = 1'b0;
    repeat (2) begin
      @(negedge clock);
      check_outputs_zero("reset_mid_no_ack");
    end
    qa.push_back('{1'b0, 8'h05, 64'h0});
    run_queues(1'b0);
  endtask

  task automatic test_random();
    int          na, nb;
    logic [7:0]  ad;
    for (int it = 0; it < 20; it++) begin
      na = $urandom_range(0, 3);
      nb = $urandom_range(0, 3);
      if (na + nb == 0) na = 1;
      for (int k = 0; k < na + nb; k++) begin
        case ($urandom_range(0, 3))
          0:       ad = 8'h00;
          1:       ad = 8'hFF;
          default: ad = 8'($urandom_range(0, 15));
        endcase
        if (k < na) qa.push_back('{1'($urandom), ad, {$urandom, $urandom}});
        else        qb.push_back('{1'($urandom), ad, {$urandom, $urandom}});
      end
      run_queues(1'b0);
      if ($urandom_range(0, 1) == 1) @(negedge clock);
    end
  endtask

  initial begin
    test_reset();
    test_write_a();
    test_read_a();
    test_contention();
    test_back_to_back();
    test_withdraw();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
